// File: rtl/adder_tree_pipe.sv
// Pipelined signed reduction adder: registered pairwise tree over N_IN lanes, then an
// accumulate/saturate stage that sums multi-beat packets, with valid/ready backpressure.
module adder_tree_pipe #(
  parameter int N_IN  = 16,
  parameter int IN_W  = 16,
  parameter int OUT_W = 20
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*IN_W-1:0]   in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_sat
);

  localparam int LEVELS = $clog2(N_IN);
  localparam int NP     = 1 << LEVELS;
  localparam int SW     = IN_W + LEVELS;
  localparam int AW     = ((OUT_W > SW) ? OUT_W : SW) + 1;
  localparam int PW     = NP * IN_W;

  localparam logic signed [AW-1:0] MAX_V = {{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_V = {{(AW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic over_range(input logic signed [AW-1:0] v);
    return (v > MAX_V) || (v < MIN_V);
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [AW-1:0] v);
    if (v > MAX_V) return MAX_V[OUT_W-1:0];
    if (v < MIN_V) return MIN_V[OUT_W-1:0];
    return v[OUT_W-1:0];
  endfunction

  logic                     adv;
  logic [PW-1:0]            pad_data;
  // Heap-ordered tree: leaves at NP-1..2*NP-2 (stage 0), node i sums children 2i+1, 2i+2,
  // so the root node_p[0] lands at stage LEVELS.
  logic signed [SW-1:0]     node_p [0:2*NP-2];
  logic [LEVELS:0]          vld_p;
  logic [LEVELS:0]          last_p;
  logic signed [OUT_W-1:0]  acc;
  logic                     sticky;
  logic signed [AW-1:0]     total;
  logic                     clamp;
  logic signed [OUT_W-1:0]  total_sat;

  assign adv      = !out_valid || out_ready;
  assign in_ready = reset_n && adv;
  assign pad_data = PW'(in_data);

  // Stage 0 .. LEVELS: lane registers and tree levels
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int j = 0; j < NP; j++)
        node_p[NP-1+j] <= SW'($signed(pad_data[j*IN_W +: IN_W]));
      for (int i = 0; i < NP-1; i++)
        node_p[i] <= node_p[2*i+1] + node_p[2*i+2];
      last_p <= {last_p[LEVELS-1:0], in_last};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      vld_p <= '0;
    else if (adv)
      vld_p <= {vld_p[LEVELS-1:0], in_valid};
  end

  assign total     = AW'(acc) + AW'(node_p[0]);
  assign clamp     = over_range(total);
  assign total_sat = saturate(total);

  // Stage LEVELS+1: accumulate / saturate / present result
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc       <= '0;
      sticky    <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= 1'b0;
      if (vld_p[LEVELS]) begin
        if (last_p[LEVELS]) begin
          out_data  <= total_sat;
          out_sat   <= sticky || clamp;
          out_valid <= 1'b1;
          acc       <= '0;
          sticky    <= 1'b0;
        end else begin
          acc    <= total_sat;
          sticky <= sticky || clamp;
        end
      end
    end
  end

endmodule
